// File: rtl/rom_stream_pkg.sv
// rtl/rom_stream_pkg.sv - shared types and helpers for the ROM stream reader
package rom_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Ceiling log2, never below 1 so single-entry structures still get a bit.
    function automatic int clog2(input int value);
        int r;
        for (r = 1; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/rom_stream_fifo.sv
// rtl/rom_stream_fifo.sv - registered show-ahead FIFO holding {last, data}
module rom_stream_fifo
    import rom_stream_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int FIFO_AW = clog2(DEPTH);
    localparam int CNT_W   = clog2(DEPTH + 1);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               pop_ok;

    function automatic logic [FIFO_AW-1:0] ptr_inc(input logic [FIFO_AW-1:0] p);
        return (p == FIFO_AW'(DEPTH - 1)) ? '0 : p + FIFO_AW'(1);
    endfunction

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign pop_ok     = pop_i && !empty_o;
    // Head entry is shown directly; an empty FIFO presents zeros.
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage array: written on push, needs no reset since empty masks it.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// rtl/rom_stream_reader.sv - ROM read sequencer with credit-limited issue and stream output
module rom_stream_reader
    import rom_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  rom_clken,
    output logic                  rom_read_en,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0] rom_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int CNT_W = clog2(FIFO_DEPTH + 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [LATENCY-1:0]    vpipe_q, vpipe_d;
    logic [LATENCY-1:0]    lpipe_q, lpipe_d;
    logic                  zero_done_q, zero_done_d;

    logic                  issue;
    logic                  credit;
    logic                  pop;
    logic                  drain_done;
    logic                  fifo_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH:0]   fifo_head;

    assign rom_clken   = 1'b1;
    assign rom_read_en = issue;
    assign rom_address = addr_cnt_q;
    assign busy        = (state_q != IDLE);
    assign out_valid   = !fifo_empty;
    assign out_last    = fifo_head[DATA_WIDTH];
    assign out_data    = fifo_head[DATA_WIDTH-1:0];
    assign pop         = out_valid && out_ready;
    assign done        = zero_done_q || drain_done;
    // The pipe tail marks the cycle the ROM data for an issue is on the bus;
    // the full guard is defensive since credit already bounds occupancy.
    assign fifo_push   = vpipe_q[LATENCY-1] && (!fifo_full || pop);

    // Next-state, issue decision, credit accounting and return-pipe shift.
    always_comb begin
        state_d       = state_q;
        addr_cnt_d    = addr_cnt_q;
        remaining_d   = remaining_q;
        zero_done_d   = 1'b0;
        issue         = 1'b0;
        drain_done    = 1'b0;
        credit        = (outstanding_q < CNT_W'(FIFO_DEPTH)) ||
                        ((outstanding_q == CNT_W'(FIFO_DEPTH)) && pop);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        addr_cnt_d  = base_addr;
                        remaining_d = num_words;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if ((remaining_q != '0) && credit) begin
                    issue       = 1'b1;
                    addr_cnt_d  = addr_cnt_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - (ADDR_WIDTH + 1)'(1);
                    if (remaining_q == (ADDR_WIDTH + 1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    drain_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(pop);

        vpipe_d[0] = issue;
        lpipe_d[0] = issue && (remaining_q == (ADDR_WIDTH + 1)'(1));
        for (int i = 1; i < LATENCY; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
            lpipe_d[i] = lpipe_q[i-1];
        end
    end

    // State and counters; reset also drops any ROM returns still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_cnt_q    <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            vpipe_q       <= '0;
            lpipe_q       <= '0;
            zero_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_cnt_q    <= addr_cnt_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            vpipe_q       <= vpipe_d;
            lpipe_q       <= lpipe_d;
            zero_done_q   <= zero_done_d;
        end
    end

    rom_stream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i ({lpipe_q[LATENCY-1], rom_read_data}),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb/tb_rom_stream_reader.sv - randomized scoreboard bench for two reader configurations
module tb_rom_stream_reader;

    typedef struct {
        logic [31:0] d;
        bit          last;
    } item_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  start = 2'b00;
    logic [1:0]  out_ready = 2'b11;
    logic [3:0]  base_addr [2];
    logic [4:0]  num_words [2];
    wire  [1:0]  out_valid;
    wire  [1:0]  done;
    logic [31:0] rom_mem [16];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Instance 0: LATENCY=1, instance 1: LATENCY=3; both 16-word ROM, 4-entry FIFO.
    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : 3;

        wire         busy_w;
        wire         clken_w;
        wire         rd_en_w;
        wire  [3:0]  addr_w;
        wire  [31:0] data_w;
        wire         last_w;
        logic [31:0] rom_pipe [L];
        wire  [31:0] rom_rd;

        rom_stream_reader #(
            .DATA_WIDTH (32),
            .ADDR_WIDTH (4),
            .LATENCY    (L),
            .FIFO_DEPTH (4)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .start         (start[g]),
            .base_addr     (base_addr[g]),
            .num_words     (num_words[g]),
            .busy          (busy_w),
            .done          (done[g]),
            .rom_clken     (clken_w),
            .rom_read_en   (rd_en_w),
            .rom_address   (addr_w),
            .rom_read_data (rom_rd),
            .out_valid     (out_valid[g]),
            .out_ready     (out_ready[g]),
            .out_data      (data_w),
            .out_last      (last_w)
        );

        always @(posedge clk) begin
            rom_pipe[0] <= rom_mem[addr_w];
            for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
        end
        assign rom_rd = rom_pipe[L-1];

        item_t      exp_q[$];
        bit         active = 0;
        bit         zflag = 0;
        logic [3:0] exp_addr = '0;
        int         iss_left = 0;
        int         ocnt = 0;

        always @(negedge clk) begin
            bit    hs;
            bit    lhs;
            item_t it;
            if (reset) begin
                exp_q.delete();
                active = 0;
                zflag = 0;
                iss_left = 0;
                ocnt = 0;
            end else begin
                hs  = out_valid[g] && out_ready[g];
                lhs = 0;
                chk("busy", busy_w, active);
                chk("clken", clken_w, 1);
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_word", 1, 0);
                    end else begin
                        it = exp_q.pop_front();
                        chk("out_data", data_w, it.d);
                        chk("out_last", last_w, it.last);
                        lhs = it.last;
                    end
                end
                chk("done", done[g], zflag || lhs);
                zflag = 0;
                if (rd_en_w) begin
                    if (iss_left == 0) begin
                        chk("spurious_read", 1, 0);
                    end else begin
                        chk("rom_address", addr_w, exp_addr);
                        exp_addr = exp_addr + 4'd1;
                        iss_left--;
                    end
                end
                ocnt = ocnt + int'(rd_en_w) - int'(hs);
                chk("outstanding_le_depth", ocnt <= 4, 1);
                if (start[g] && !active) begin
                    if (num_words[g] == 0) begin
                        zflag = 1;
                    end else begin
                        active = 1;
                        exp_addr = base_addr[g];
                        iss_left = num_words[g];
                        for (int i = 0; i < int'(num_words[g]); i++)
                            exp_q.push_back('{d: rom_mem[4'(int'(base_addr[g]) + i)],
                                              last: (i == int'(num_words[g]) - 1)});
                    end
                end
                if (lhs) active = 0;
            end
        end

        always @(posedge reset) begin
            #1;
            chk("rst_busy", busy_w, 0);
            chk("rst_done", done[g], 0);
            chk("rst_read_en", rd_en_w, 0);
            chk("rst_address", addr_w, 0);
            chk("rst_valid", out_valid[g], 0);
            chk("rst_last", last_w, 0);
            chk("rst_data", data_w, 0);
        end
    end

    // Issues one command on instance k and runs until done or a cycle budget expires.
    // mode 0: ready held high, 1: ready one cycle in three, 2: random ready.
    task automatic run_cmd(input int k, input int base, input int n, input int mode,
                           input bit inj, output int first_v, output int done_c);
        int cyc;
        @(posedge clk); #1;
        base_addr[k] = 4'(base);
        num_words[k] = 5'(n);
        start[k] = 1'b1;
        cyc = 0;
        first_v = -1;
        done_c = -1;
        while (cyc < 400 && done_c < 0) begin
            out_ready[k] = (mode == 0) ? 1'b1 :
                           (mode == 1) ? ((cyc % 3) == 2) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (out_valid[k] && first_v < 0) first_v = cyc;
            if (done[k]) done_c = cyc;
            @(posedge clk); #1;
            start[k] = 1'b0;
            if (inj && cyc == 3) begin
                start[k] = 1'b1;
                base_addr[k] = 4'd0;
                num_words[k] = 5'd3;
            end
            cyc++;
        end
        start[k] = 1'b0;
        out_ready[k] = 1'b1;
        chk("done_seen", done_c >= 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill_rom(input bit identity);
        for (int i = 0; i < 16; i++) rom_mem[i] = identity ? 32'(i) : $urandom;
    endtask

    initial begin
        int fv;
        int dc;
        int k;
        int n;
        base_addr[0] = '0; base_addr[1] = '0;
        num_words[0] = '0; num_words[1] = '0;
        fill_rom(1);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(2);

        for (k = 0; k < 2; k++) begin
            run_cmd(k, 5, 8, 0, 0, fv, dc);
            chk("first_valid_latency", fv, lat_of(k) + 2);
            chk("done_cycle", dc, lat_of(k) + 8 + 1);
            idle(3);
        end

        fill_rom(0);
        run_cmd(1, $urandom_range(0, 15), 16, 1, 0, fv, dc);
        idle(3);

        for (k = 0; k < 2; k++) begin
            run_cmd(k, 14, 4, 0, 0, fv, dc);
            chk("wrap_done_cycle", dc, lat_of(k) + 4 + 1);
            idle(3);
            run_cmd(k, 9, 0, 0, 0, fv, dc);
            chk("zero_done_cycle", dc, 1);
            idle(3);
        end

        run_cmd(1, 3, 6, 0, 1, fv, dc);
        chk("busy_start_done_cycle", dc, 3 + 6 + 1);
        idle(3);

        for (int it = 0; it < 12; it++) begin
            fill_rom(0);
            k = $urandom_range(0, 1);
            n = $urandom_range(0, 16);
            run_cmd(k, $urandom_range(0, 15), n, 2, 0, fv, dc);
            if (n == 0) chk("rand_zero_done", dc, 1);
            idle(3);
        end

        fill_rom(0);
        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        base_addr[1] = 4'd7;
        num_words[1] = 5'd10;
        start[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        out_ready[1] = 1'b1;
        idle(2);
        run_cmd(1, 0, 2, 0, 0, fv, dc);
        chk("post_reset_done_cycle", dc, 3 + 2 + 1);
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
